// File: rtl/calc_op_sequencer.sv
// Operation sequencer for the shared 8-bit add/sub unit: single-cycle ADD/SUB,
// eight-iteration shift-add MUL and restoring DIV, with valid/ready on both sides.
module calc_op_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        carry,
    output logic        err,
    output logic        busy,
    output logic [7:0]  as_a,
    output logic [7:0]  as_b,
    output logic        as_sub,
    input  logic [7:0]  as_s,
    input  logic        as_c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [7:0]  hi_r;
    logic [7:0]  lo_r;
    logic [2:0]  cnt_r;
    logic [15:0] result_r;
    logic        carry_r;
    logic        err_r;
    logic        res_valid_r;

    logic        div_top_s;
    logic [7:0]  rem_sh_s;
    logic [7:0]  quo_sh_s;
    logic [8:0]  mul_acc_s;
    logic [7:0]  hi_next_s;
    logic [7:0]  lo_next_s;

    // hi/lo hold HI/LO for MUL and R/Q for DIV; this computes one iteration step.
    always_comb begin
        div_top_s = hi_r[7];
        rem_sh_s  = {hi_r[6:0], lo_r[7]};
        quo_sh_s  = {lo_r[6:0], 1'b0};
        if (lo_r[0]) begin
            mul_acc_s = {as_c, as_s};
        end else begin
            mul_acc_s = {1'b0, hi_r};
        end
        if (op_r == OP_MUL) begin
            hi_next_s = mul_acc_s[8:1];
            lo_next_s = {mul_acc_s[0], lo_r[7:1]};
        end else if (div_top_s || as_c) begin
            hi_next_s = as_s;
            lo_next_s = quo_sh_s | 8'h01;
        end else begin
            hi_next_s = rem_sh_s;
            lo_next_s = quo_sh_s;
        end
    end

    // Add/sub unit operand bus, decoded from state and datapath registers.
    always_comb begin
        as_a   = 8'h00;
        as_b   = 8'h00;
        as_sub = 1'b0;
        case (state_r)
            EXEC: begin
                if (op_r != OP_DIV) begin
                    as_a   = a_r;
                    as_b   = b_r;
                    as_sub = op_r[0];
                end else begin
                    as_a   = 8'h00;
                    as_b   = 8'h00;
                    as_sub = 1'b0;
                end
            end
            ITER: begin
                if (op_r == OP_MUL) begin
                    as_a   = hi_r;
                    as_b   = a_r;
                    as_sub = 1'b0;
                end else begin
                    as_a   = rem_sh_s;
                    as_b   = b_r;
                    as_sub = 1'b1;
                end
            end
            default: begin
                as_a   = 8'h00;
                as_b   = 8'h00;
                as_sub = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with its datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            op_r        <= OP_ADD;
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            hi_r        <= 8'h00;
            lo_r        <= 8'h00;
            cnt_r       <= 3'd0;
            result_r    <= 16'h0000;
            carry_r     <= 1'b0;
            err_r       <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        cnt_r <= 3'd0;
                        hi_r  <= 8'h00;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                state_r <= EXEC;
                            end
                            OP_MUL: begin
                                lo_r    <= b;
                                state_r <= ITER;
                            end
                            default: begin
                                lo_r <= a;
                                // Divide-by-zero is resolved in a single EXEC cycle.
                                if (b == 8'h00) begin
                                    state_r <= EXEC;
                                end else begin
                                    state_r <= ITER;
                                end
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (op_r == OP_DIV) begin
                        result_r <= {a_r, 8'hFF};
                        carry_r  <= 1'b0;
                        err_r    <= 1'b1;
                    end else begin
                        result_r <= {8'h00, as_s};
                        carry_r  <= as_c;
                        err_r    <= 1'b0;
                    end
                    res_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                ITER: begin
                    hi_r  <= hi_next_s;
                    lo_r  <= lo_next_s;
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        result_r    <= {hi_next_s, lo_next_s};
                        carry_r     <= 1'b0;
                        err_r       <= 1'b0;
                        res_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign res_valid   = res_valid_r;
    assign result      = result_r;
    assign carry       = carry_r;
    assign err         = err_r;

endmodule

// Handshake invariants of calc_op_sequencer, observed from its ports only.
module calc_op_sequencer_checker (
    input logic        clk,
    input logic        rst,
    input logic        start_ready,
    input logic        busy,
    input logic        res_valid,
    input logic        res_ready,
    input logic [15:0] result,
    input logic        carry,
    input logic        err
);

    ready_busy_exclusive: assert property (@(posedge clk) disable iff (rst)
        busy != start_ready);

    valid_implies_busy: assert property (@(posedge clk) disable iff (rst)
        res_valid |-> busy);

    result_held_under_backpressure: assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=> (res_valid && $stable(result) && $stable(carry) && $stable(err)));

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: behavioural add/sub unit plus an
// arithmetic reference model, directed vectors and $urandom stimulus.
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] result;
    logic        carry;
    logic        err;
    logic        busy;
    logic [7:0]  as_a;
    logic [7:0]  as_b;
    logic        as_sub;
    logic [7:0]  as_s;
    logic        as_c;
    logic [8:0]  as_sum;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    calc_op_sequencer dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .carry(carry), .err(err), .busy(busy),
        .as_a(as_a), .as_b(as_b), .as_sub(as_sub), .as_s(as_s), .as_c(as_c)
    );

    calc_op_sequencer_checker u_chk (
        .clk(clk), .rst(rst), .start_ready(start_ready), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .carry(carry), .err(err)
    );

    // External add/sub unit: A + (sub ? ~B : B) + sub, carry-out is bit 8.
    assign as_sum = {1'b0, as_a} + {1'b0, (as_sub ? ~as_b : as_b)} + {8'd0, as_sub};
    assign as_s   = as_sum[7:0];
    assign as_c   = as_sum[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {err, carry, result} from plain arithmetic.
    function automatic logic [17:0] ref_model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int s;
        case (o)
            2'b00: begin
                s = int'(x) + int'(y);
                ref_model = {1'b0, (s > 255), 8'h00, 8'(s)};
            end
            2'b01: ref_model = {1'b0, (x >= y), 8'h00, 8'(int'(x) - int'(y))};
            2'b10: ref_model = {2'b00, 16'(int'(x) * int'(y))};
            default: begin
                if (y == 8'h00) ref_model = {2'b10, x, 8'hFF};
                else            ref_model = {2'b00, 8'(x % y), 8'(x / y)};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         output logic rdy, output int acc);
        start_valid = 1'b1;
        op = o; a = x; b = y;
        rdy = start_ready;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        start_valid = 1'b0;
        op = 2'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // Counts edges until res_valid is seen, recording as_sub while working.
    task automatic wait_result(output int lat, output logic sub_any, output logic sub_all);
        lat = 0;
        sub_any = 1'b0;
        sub_all = 1'b1;
        while (res_valid !== 1'b1 && lat < 40) begin
            sub_any = sub_any | as_sub;
            sub_all = sub_all & as_sub;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({res_valid, busy, start_ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_flags: got %b want 001", {res_valid, busy, start_ready});
        end
        tests++;
        if ({err, carry, result} !== 18'h00000) begin
            fails++;
            $display("FAIL reset_result: got %h want 00000", {err, carry, result});
        end
        tests++;
        if ({as_a, as_b, as_sub} !== 17'h00000) begin
            fails++;
            $display("FAIL reset_as_bus: got %h want 00000", {as_a, as_b, as_sub});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        logic [1:0] o;
        logic [7:0] x, y;
        logic rdy, sa, sl;
        logic [17:0] exp;
        int acc, lat;
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0: begin o = 2'b00; x = 8'hC8; y = 8'h64; exp = 18'h1002C; end
                1: begin o = 2'b01; x = 8'h05; y = 8'h07; exp = 18'h000FE; end
                2: begin o = 2'b01; x = 8'h07; y = 8'h05; exp = 18'h10002; end
                default: begin
                    o = {1'b0, 1'($urandom)};
                    x = 8'($urandom);
                    y = 8'($urandom);
                    exp = ref_model(o, x, y);
                end
            endcase
            issue(o, x, y, rdy, acc);
            wait_result(lat, sa, sl);
            tests++;
            if (rdy !== 1'b1 || lat !== 1) begin
                fails++;
                $display("FAIL addsub_timing[%0d]: ready %b latency %0d want ready 1 latency 1", i, rdy, lat);
            end
            tests++;
            if ({err, carry, result} !== exp) begin
                fails++;
                $display("FAIL addsub_result[%0d] op %0d %h,%h: got %h want %h", i, o, x, y, {err, carry, result}, exp);
            end
            tests++;
            if (sa !== o[0] || sl !== o[0]) begin
                fails++;
                $display("FAIL addsub_as_sub[%0d]: got any %b all %b want %b", i, sa, sl, o[0]);
            end
            @(posedge clk);
            @(negedge clk);
            tests++;
            if ({start_ready, res_valid, busy} !== 3'b100) begin
                fails++;
                $display("FAIL addsub_return_idle[%0d]: got %b want 100", i, {start_ready, res_valid, busy});
            end
        end
    endtask

    task automatic test_mul();
        logic [7:0] x, y;
        logic rdy, sa, sl;
        logic [17:0] exp;
        int acc, lat;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin x = 8'hFF; y = 8'hFF; exp = 18'h0FE01; end
                1: begin x = 8'h00; y = 8'h5A; exp = 18'h00000; end
                2: begin x = 8'h0D; y = 8'h0B; exp = 18'h0008F; end
                default: begin
                    x = 8'($urandom);
                    y = 8'($urandom);
                    exp = ref_model(2'b10, x, y);
                end
            endcase
            issue(2'b10, x, y, rdy, acc);
            wait_result(lat, sa, sl);
            tests++;
            if (rdy !== 1'b1 || lat !== 8) begin
                fails++;
                $display("FAIL mul_timing[%0d]: ready %b latency %0d want ready 1 latency 8", i, rdy, lat);
            end
            tests++;
            if ({err, carry, result} !== exp) begin
                fails++;
                $display("FAIL mul_result[%0d] %h*%h: got %h want %h", i, x, y, {err, carry, result}, exp);
            end
            tests++;
            if (sa !== 1'b0) begin
                fails++;
                $display("FAIL mul_as_sub[%0d]: got %b want 0", i, sa);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        logic [7:0] x, y;
        logic rdy, sa, sl;
        logic [17:0] exp;
        int acc, lat, exp_lat;
        res_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0: begin x = 8'hC8; y = 8'h07; exp = 18'h0041C; end
                1: begin x = 8'hFF; y = 8'h01; exp = 18'h000FF; end
                2: begin x = 8'h80; y = 8'h81; exp = 18'h08000; end
                3: begin x = 8'h33; y = 8'h00; exp = 18'h233FF; end
                default: begin
                    x = 8'($urandom);
                    y = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                    exp = ref_model(2'b11, x, y);
                end
            endcase
            exp_lat = (y == 8'h00) ? 1 : 8;
            issue(2'b11, x, y, rdy, acc);
            wait_result(lat, sa, sl);
            tests++;
            if (rdy !== 1'b1 || lat !== exp_lat) begin
                fails++;
                $display("FAIL div_timing[%0d]: ready %b latency %0d want ready 1 latency %0d", i, rdy, lat, exp_lat);
            end
            tests++;
            if ({err, carry, result} !== exp) begin
                fails++;
                $display("FAIL div_result[%0d] %h/%h: got %h want %h", i, x, y, {err, carry, result}, exp);
            end
            tests++;
            if ({sa, sl} !== ((y == 8'h00) ? 2'b00 : 2'b11)) begin
                fails++;
                $display("FAIL div_as_sub[%0d]: got any %b all %b for divisor %h", i, sa, sl, y);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic rdy, sa, sl;
        int acc, lat;
        res_ready = 1'b0;
        issue(2'b10, 8'h0D, 8'h0B, rdy, acc);
        wait_result(lat, sa, sl);
        tests++;
        if (rdy !== 1'b1 || lat !== 8 || {err, carry, result} !== 18'h0008F) begin
            fails++;
            $display("FAIL bp_first_result: ready %b latency %0d value %h want 1, 8, 0008F", rdy, lat, {err, carry, result});
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 3) start_valid = 1'b0;
            tests++;
            if ({res_valid, start_ready, busy} !== 3'b101 || {err, carry, result} !== 18'h0008F) begin
                fails++;
                $display("FAIL bp_hold[%0d]: flags %b value %h want 101, 0008F", k, {res_valid, start_ready, busy}, {err, carry, result});
            end
            if (k == 2) begin
                start_valid = 1'b1;
                op = 2'b00; a = 8'h01; b = 8'h01;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({start_ready, res_valid} !== 2'b10 || {err, carry, result} !== 18'h0008F) begin
            fails++;
            $display("FAIL bp_release: flags %b value %h want 10, 0008F", {start_ready, res_valid}, {err, carry, result});
        end
        issue(2'b00, 8'h10, 8'h20, rdy, acc);
        wait_result(lat, sa, sl);
        tests++;
        if (rdy !== 1'b1 || lat !== 1 || {err, carry, result} !== 18'h00030) begin
            fails++;
            $display("FAIL bp_next_accept: ready %b latency %0d value %h want 1, 1, 00030", rdy, lat, {err, carry, result});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] o;
        logic [7:0] x, y;
        logic rdy, sa, sl;
        logic [17:0] exp;
        int acc, prev_acc, prev_gap, lat;
        res_ready = 1'b1;
        prev_acc = 0;
        prev_gap = 0;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            exp = ref_model(o, x, y);
            issue(o, x, y, rdy, acc);
            if (i > 0) begin
                tests++;
                if (acc - prev_acc !== prev_gap) begin
                    fails++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", i, acc - prev_acc, prev_gap);
                end
            end
            prev_acc = acc;
            prev_gap = (o[1] == 1'b0 || (o == 2'b11 && y == 8'h00)) ? 3 : 10;
            wait_result(lat, sa, sl);
            tests++;
            if (rdy !== 1'b1 || {err, carry, result} !== exp) begin
                fails++;
                $display("FAIL b2b_result[%0d] op %0d %h,%h: ready %b got %h want %h", i, o, x, y, rdy, {err, carry, result}, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_div();
        logic rdy, sa, sl;
        int acc, lat;
        res_ready = 1'b1;
        issue(2'b11, 8'hC8, 8'h07, rdy, acc);
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({res_valid, busy} !== 2'b01) begin
            fails++;
            $display("FAIL mid_div_running: flags %b want 01", {res_valid, busy});
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({res_valid, busy, start_ready} !== 3'b001 || result !== 16'h0000) begin
            fails++;
            $display("FAIL mid_div_reset: flags %b result %h want 001, 0000", {res_valid, busy, start_ready}, result);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({res_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL mid_div_no_result: flags %b want 00", {res_valid, busy});
        end
        issue(2'b00, 8'h01, 8'h01, rdy, acc);
        wait_result(lat, sa, sl);
        tests++;
        if (rdy !== 1'b1 || lat !== 1 || {err, carry, result} !== 18'h00002) begin
            fails++;
            $display("FAIL post_reset_add: ready %b latency %0d value %h want 1, 1, 00002", rdy, lat, {err, carry, result});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle operation sequencer for the 8-bit binary add/subtract unit used by the calculator datapath. It accepts an operation and two 8-bit unsigned operands over a valid/ready handshake. It then drives the shared add/sub unit for one cycle (ADD, SUB) or eight iterations (shift-add MUL, restoring DIV), and returns a 16-bit result over a second valid/ready handshake. The add/sub unit is external; this block owns its operand and mode inputs.

## Interface
- No parameters; operand width fixed at 8, result width 16.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  request present
- start_ready  out  1  block can accept a request (high only in IDLE)
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled at accept
- a  in  8  operand A (dividend for DIV); sampled at accept
- b  in  8  operand B (divisor for DIV); sampled at accept
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  16  ADD/SUB: {8'h00, sum}; MUL: product; DIV: {remainder, quotient}
- carry  out  1  ADD: carry-out; SUB: 1 = no borrow (A>=B); MUL/DIV: 0
- err  out  1  DIV with b==0
- busy  out  1  high in EXEC, ITER, DONE
- as_a  out  8  add/sub unit operand A
- as_b  out  8  add/sub unit operand B (uncomplemented)
- as_sub  out  1  add/sub unit mode/carry-in (1 = A-B)
- as_s  in  8  add/sub unit sum
- as_c  in  1  add/sub unit carry-out (C_8)

## Operation
- States: IDLE, EXEC, ITER, DONE. Reset: IDLE, res_valid=0, result=0, carry=0, err=0, busy=0, iteration count=0. start_ready is 1 in IDLE.
- Accept on start_valid && start_ready. Latch op, a, b. Later input changes are ignored.
- Transitions out of IDLE on accept:
  - ADD/SUB → EXEC.
  - MUL → ITER.
  - DIV with b!=0 → ITER.
  - DIV with b==0 → EXEC, which produces the error result.
- EXEC, ADD/SUB: as_a=A, as_b=B, as_sub=op[0]. Capture result={8'h00, as_s} and carry=as_c → DONE.
- EXEC, DIV by zero: result={A, 8'hFF}, err=1, carry=0 → DONE. The adder is not used.
- ITER, MUL (unsigned shift-add): init HI=0, LO=B.
  - Each iteration: as_a=HI, as_b=A, as_sub=0.
  - If LO[0]=1, {c,HI}={as_c, as_s}; otherwise {c,HI}={0,HI}.
  - Then {HI,LO}={c,HI,LO}>>1.
  - After 8 iterations result={HI,LO}, carry=0.
- ITER, DIV (unsigned restoring): init R=0, Q=A.
  - Each iteration: t=R[7]; R'={R[6:0],Q[7]}; Q'={Q[6:0],0}.
  - Drive as_a=R', as_b=B, as_sub=1.
  - If t || as_c: R=as_s, Q=Q'|1. Otherwise R=R', Q=Q'.
  - After 8 iterations result={R,Q}, carry=0, err=0.
- 3-bit iteration counter counts 0..7. The transition to DONE occurs on the edge that completes count 7. The counter clears on accept.
- DONE: res_valid=1. result, carry and err are held stable until res_ready. On res_valid && res_ready → IDLE and res_valid=0. result, carry and err retain their values until the next capture.
- In IDLE and DONE, as_a=0, as_b=0, as_sub=0.
- No overlap: start_ready=0 from accept until the cycle after the result handshake. start_valid is ignored while busy.
- Reset asserted in any state: immediate return to reset values. The in-flight operation is discarded and no result is produced.

## Timing
- Accept edge = E0.
- ADD, SUB, DIV-by-zero: res_valid rises at E1.
- MUL, DIV: res_valid rises at E8.
- The add/sub unit is combinational; as_s/as_c are consumed in the same cycle as_a/as_b/as_sub are driven. No added pipeline stage.
- Earliest next accept: the edge after the result handshake edge.
- Sustained throughput: ADD/SUB one op per 3 cycles; MUL/DIV one op per 10 cycles, with res_ready held high.
- All outputs are registered except start_ready, busy and the as_* bus. Those are decoded from state and datapath registers.

## Test plan
- ADD a=0xC8, b=0x64, res_ready=1 → res_valid at E1, result=0x002C, carry=1, err=0. Then start_ready=1 on the following cycle.
- SUB a=0x05, b=0x07 → result=0x00FE, carry=0. SUB a=0x07, b=0x05 → result=0x0002, carry=1.
- MUL 0xFF×0xFF → result=0xFE01 at E8. MUL 0x00×0x5A → 0x0000. MUL 0x0D×0x0B → 0x008F. as_sub=0 throughout ITER.
- DIV 200/7 → result=0x041C at E8. DIV 0xFF/0x01 → 0x00FF. DIV 0x80/0x81 → 0x8000. DIV a=0x33, b=0 → result=0x33FF, err=1 at E1.
- Backpressure: MUL completes with res_ready=0 for 5 cycles. result, carry and res_valid stay stable, start_ready=0, and a start_valid pulse is ignored. Raising res_ready → IDLE, then a new accept.
- Reset asserted mid-DIV (after 4 iterations): res_valid=0, result=0, busy=0, start_ready=1 immediately. After release, ADD 1+1 → 0x0002 normally.
